// File: rtl/fll_cfg_target.sv
// fll_cfg_target: FLL-side req/ack register target holding the FLL config/status
// registers, driving the loop controls and running the lock detector.
module fll_cfg_target (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        req,
   input  logic        wrn,
   input  logic [1:0]  add,
   input  logic [31:0] data,
   output logic        ack,
   output logic [31:0] r_data,
   output logic        lock,
   input  logic        meas_valid,
   input  logic [15:0] meas_count,
   output logic [15:0] mult_factor,
   output logic [9:0]  dco_code,
   output logic        open_loop,
   output logic [3:0]  loop_gain,
   output logic [15:0] integ_preset,
   output logic        integ_load
);
   localparam logic [31:0] c_conf1_rst  = 32'h8100_05F5;
   localparam logic [31:0] c_conf2_rst  = 32'h0040_6087;
   localparam logic [31:0] c_conf1_mask = 32'h83FF_FFFF;
   localparam logic [31:0] c_conf2_mask = 32'h00FF_FFFF;
   localparam logic [31:0] c_integ_mask = 32'h0000_FFFF;

   typedef enum logic {S_IDLE, S_ACK} state_t;

   state_t      r_state, w_state_nx;
   logic        r_req_s1, r_req_s2;
   logic [31:0] r_conf1, r_conf2, r_integ, r_rd;
   logic [15:0] r_meas;
   logic        r_lock, r_integ_load;
   logic [7:0]  r_cnt;
   logic        w_access, w_wr, w_rd, w_cfg_wr;
   logic [31:0] w_rd_val;
   logic [16:0] w_diff;
   logic        w_in_tol, w_hit, w_fire, w_lock_nx;
   logic [5:0]  w_asrt, w_deas, w_thr;
   logic [7:0]  w_cnt_nx;

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_req_s1 <= 1'b0;
         r_req_s2 <= 1'b0;
         r_state  <= S_IDLE;
      end else begin
         r_req_s1 <= req;
         r_req_s2 <= r_req_s1;
         r_state  <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_access   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_access   = r_req_s2;
            w_state_nx = r_req_s2 ? S_ACK : S_IDLE;
         end
         S_ACK:   w_state_nx = r_req_s2 ? S_ACK : S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   assign w_wr     = w_access & ~wrn;
   assign w_rd     = w_access & wrn;
   assign w_cfg_wr = w_wr & (add == 2'd1 || add == 2'd2);

   always_comb begin
      w_rd_val = add == 2'd0 ? {15'd0, r_lock, r_meas} :
                 add == 2'd1 ? r_conf1 :
                 add == 2'd2 ? r_conf2 : r_integ;
   end

   // Lock detector: counts consecutive samples disagreeing with the current lock state
   always_comb begin
      w_diff    = meas_count >= r_conf1[15:0] ? {1'b0, meas_count - r_conf1[15:0]}
                                              : {1'b0, r_conf1[15:0] - meas_count};
      w_in_tol  = w_diff <= {9'd0, r_conf2[11:4]};
      w_asrt    = r_conf2[17:12] == 6'd0 ? 6'd1 : r_conf2[17:12];
      w_deas    = r_conf2[23:18] == 6'd0 ? 6'd1 : r_conf2[23:18];
      w_thr     = r_lock ? w_deas : w_asrt;
      w_hit     = r_lock ? ~w_in_tol : w_in_tol;
      w_fire    = meas_valid & w_hit & (({1'b0, r_cnt} + 9'd1) >= {3'd0, w_thr});
      w_lock_nx = r_conf1[31] ? 1'b0 : w_fire ? ~r_lock : r_lock;
      w_cnt_nx  = (r_conf1[31] | w_cfg_wr) ? 8'd0 :
                  !meas_valid              ? r_cnt :
                  (!w_hit | w_fire)        ? 8'd0 : r_cnt + 8'd1;
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_conf1      <= c_conf1_rst;
         r_conf2      <= c_conf2_rst;
         r_integ      <= 32'd0;
         r_rd         <= 32'd0;
         r_meas       <= 16'd0;
         r_lock       <= 1'b0;
         r_cnt        <= 8'd0;
         r_integ_load <= 1'b0;
      end else begin
         r_conf1      <= (w_wr && add == 2'd1) ? data & c_conf1_mask : r_conf1;
         r_conf2      <= (w_wr && add == 2'd2) ? data & c_conf2_mask : r_conf2;
         r_integ      <= (w_wr && add == 2'd3) ? data & c_integ_mask : r_integ;
         r_rd         <= w_rd ? w_rd_val : r_rd;
         r_meas       <= meas_valid ? meas_count : r_meas;
         r_lock       <= w_lock_nx;
         r_cnt        <= w_cnt_nx;
         r_integ_load <= w_wr && add == 2'd3;
      end
   end

   assign ack          = r_state == S_ACK;
   assign r_data       = r_rd;
   assign lock         = r_lock;
   assign mult_factor  = r_conf1[15:0];
   assign dco_code     = r_conf1[25:16];
   assign open_loop    = r_conf1[31];
   assign loop_gain    = r_conf2[3:0];
   assign integ_preset = r_integ[15:0];
   assign integ_load   = r_integ_load;
endmodule

// File: tb/tb_fll_cfg_target.sv
// tb_fll_cfg_target: table-driven register accesses with a read-data scoreboard,
// plus hand sequences for lock detection and same-cycle corner cases.
module tb_fll_cfg_target;
   logic        HCLK = 1'b0;
   logic        HRESETn, req, wrn, meas_valid;
   logic [1:0]  add;
   logic [31:0] data, r_data;
   logic [15:0] meas_count, mult_factor, integ_preset;
   logic        ack, lock, open_loop, integ_load;
   logic [9:0]  dco_code;
   logic [3:0]  loop_gain;

   fll_cfg_target dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .wrn(wrn), .add(add), .data(data),
      .ack(ack), .r_data(r_data), .lock(lock), .meas_valid(meas_valid),
      .meas_count(meas_count), .mult_factor(mult_factor), .dco_code(dco_code),
      .open_loop(open_loop), .loop_gain(loop_gain), .integ_preset(integ_preset),
      .integ_load(integ_load)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic        wr_n;
      logic [1:0]  a;
      logic [31:0] d;
      logic [31:0] e;
   } vec_t;

   vec_t        vt[13];
   logic [31:0] sb[$];
   int          n_chk = 0, n_err = 0, n_load = 0;

   always @(negedge HCLK) if (integ_load) n_load++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic access(input logic w, input logic [1:0] a, input logic [31:0] d,
                         input logic [31:0] e, input string nm);
      int lat;
      if (w) sb.push_back(e);
      @(posedge HCLK); #1;
      req = 1'b1; wrn = w; add = a; data = d;
      lat = 0;
      while (!ack && lat < 10) begin @(posedge HCLK); #1; lat++; end
      chk({nm, "_ack_rise"}, 32'(lat), 32'd3);
      if (w && sb.size() > 0) chk(nm, r_data, sb.pop_front());
      req = 1'b0;
      lat = 0;
      while (ack && lat < 10) begin @(posedge HCLK); #1; lat++; end
      chk({nm, "_ack_fall"}, 32'(lat), 32'd3);
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++)
         access(vt[i].wr_n, vt[i].a, vt[i].d, vt[i].e, $sformatf("vec%0d", i));
   endtask

   task automatic pulse(input logic [15:0] c);
      @(posedge HCLK); #1;
      meas_valid = 1'b1; meas_count = c;
      @(posedge HCLK); #1;
      meas_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int l0;
      vt[0]  = '{1'b1, 2'd0, 32'h0,         32'h0000_0000};
      vt[1]  = '{1'b1, 2'd1, 32'h0,         32'h8100_05F5};
      vt[2]  = '{1'b1, 2'd2, 32'h0,         32'h0040_6087};
      vt[3]  = '{1'b1, 2'd3, 32'h0,         32'h0000_0000};
      vt[4]  = '{1'b0, 2'd1, 32'h0000_0100, 32'h0};
      vt[5]  = '{1'b1, 2'd1, 32'h0,         32'h0000_0100};
      vt[6]  = '{1'b0, 2'd3, 32'hDEAD_1234, 32'h0};
      vt[7]  = '{1'b1, 2'd3, 32'h0,         32'h0000_1234};
      vt[8]  = '{1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0};
      vt[9]  = '{1'b1, 2'd0, 32'h0,         32'h0000_0120};
      vt[10] = '{1'b0, 2'd2, 32'hFFFF_FFFF, 32'h0};
      vt[11] = '{1'b1, 2'd2, 32'h0,         32'h00FF_FFFF};
      vt[12] = '{1'b0, 2'd2, 32'h0040_6087, 32'h0};
      HRESETn = 1'b0; req = 1'b0; wrn = 1'b0; add = 2'd0; data = 32'd0;
      meas_valid = 1'b0; meas_count = 16'd0;
      repeat (3) @(posedge HCLK);
      #1 HRESETn = 1'b1;
      chk("rst_ack", {31'd0, ack}, 32'd0);
      chk("rst_lock", {31'd0, lock}, 32'd0);
      chk("rst_mult", {16'd0, mult_factor}, 32'h05F5);
      chk("rst_dco", {22'd0, dco_code}, 32'h100);
      chk("rst_open", {31'd0, open_loop}, 32'd1);
      chk("rst_gain", {28'd0, loop_gain}, 32'd7);
      chk("rst_integ_load", {31'd0, integ_load}, 32'd0);
      run_vecs(0, 5);
      chk("mult_after_wr", {16'd0, mult_factor}, 32'h0100);
      chk("open_after_wr", {31'd0, open_loop}, 32'd0);
      for (int i = 1; i <= 6; i++) begin
         pulse(16'h0104);
         if (i >= 5) chk($sformatf("lock_assert_p%0d", i), {31'd0, lock}, {31'd0, i == 6});
      end
      access(1'b1, 2'd0, 32'h0, 32'h0001_0104, "status_locked");
      repeat (15) pulse(16'h0120);
      chk("lock_hold_15", {31'd0, lock}, 32'd1);
      pulse(16'h0100);
      chk("lock_hold_reset", {31'd0, lock}, 32'd1);
      repeat (15) pulse(16'h0120);
      chk("lock_hold_15b", {31'd0, lock}, 32'd1);
      pulse(16'h0120);
      chk("lock_deassert", {31'd0, lock}, 32'd0);
      l0 = n_load;
      run_vecs(6, 6);
      chk("integ_preset", {16'd0, integ_preset}, 32'h1234);
      chk("integ_load_cnt", 32'(n_load - l0), 32'd1);
      run_vecs(7, 12);
      // CONF2 write lands on the same edge as the 5th in-tolerance sample
      repeat (4) pulse(16'h0104);
      @(posedge HCLK); #1;
      req = 1'b1; wrn = 1'b0; add = 2'd2; data = 32'h0040_6087;
      @(posedge HCLK); #1;
      @(posedge HCLK); #1;
      meas_valid = 1'b1; meas_count = 16'h0104;
      @(posedge HCLK); #1;
      meas_valid = 1'b0;
      chk("coinc_ack", {31'd0, ack}, 32'd1);
      req = 1'b0;
      repeat (4) @(posedge HCLK);
      #1 chk("coinc_ack_low", {31'd0, ack}, 32'd0);
      chk("coinc_lock", {31'd0, lock}, 32'd0);
      for (int i = 1; i <= 6; i++) begin
         pulse(16'h0104);
         if (i >= 5) chk($sformatf("coinc_lock_p%0d", i), {31'd0, lock}, {31'd0, i == 6});
      end
      access(1'b0, 2'd2, 32'h0000_6087, 32'h0, "deas_zero_wr");
      pulse(16'h0120);
      chk("deas_zero_lock", {31'd0, lock}, 32'd0);
      access(1'b0, 2'd2, 32'h0000_0087, 32'h0, "asrt_zero_wr");
      pulse(16'h0104);
      chk("asrt_zero_lock", {31'd0, lock}, 32'd1);
      access(1'b0, 2'd1, 32'h8000_0100, 32'h0, "open_wr");
      chk("open_lock", {31'd0, lock}, 32'd0);
      pulse(16'h0100);
      chk("open_lock_held", {31'd0, lock}, 32'd0);
      access(1'b1, 2'd0, 32'h0, 32'h0000_0100, "open_status");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
